// File: rtl/pipelined_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
package pipelined_rca_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Legal when WIDTH splits into STAGES equal chunks of at least one bit.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        if (stages == 0) return 1'b0;
        return (width >= 2) && (width % stages == 0);
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CW-bit ripple chunk built from full-adder cells.
module rca_chunk #(
    parameter int unsigned CW = 4
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          cin_i,
    output logic [CW-1:0] sum_o,
    output logic          cout_o,
    output logic          cmsb_o
);

    logic [CW:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < CW; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[CW];
    assign cmsb_o = carry[CW-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one CW-bit chunk per stage, global stall.
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned CW = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_rca: WIDTH must be >= 2 and divisible by STAGES >= 1");
    end

    logic              advance_c;
    logic [WIDTH-1:0]  b_eff_c;
    logic              cin_eff_c;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_cy;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_res [STAGES];

    logic [CW-1:0]     chunk_sum [STAGES];
    logic [STAGES-1:0] chunk_cout;
    logic [STAGES-1:0] chunk_cmsb;

    logic [WIDTH-1:0]  res_d [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic              ovf_d;

    assign advance_c = !out_valid || out_ready;
    assign in_ready  = advance_c;

    // Subtract is a + ~b + ~c_in, so c_in acts as a borrow-in.
    always_comb begin
        b_eff_c   = b;
        cin_eff_c = c_in;
        if (sub == MODE_SUB) begin
            b_eff_c   = ~b;
            cin_eff_c = ~c_in;
        end
    end

    // Stage k consumes either the conditioned inputs or stage k-1's registers.
    always_comb begin
        src_v[0]   = in_valid;
        src_cy[0]  = cin_eff_c;
        src_a[0]   = a;
        src_b[0]   = b_eff_c;
        src_res[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k]   = vld_q[k-1];
            src_cy[k]  = cy_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_res[k] = res_q[k-1];
        end
    end

    // Pending operand chunks are kept shifted down so the next chunk sits at bit 0.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_chunk #(
            .CW (CW)
        ) u_chunk (
            .a_i    (src_a[k][CW-1:0]),
            .b_i    (src_b[k][CW-1:0]),
            .cin_i  (src_cy[k]),
            .sum_o  (chunk_sum[k]),
            .cout_o (chunk_cout[k]),
            .cmsb_o (chunk_cmsb[k])
        );
    end

    // Lower stages leave chunk k of the partial result zero, so OR inserts it.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            res_d[k] = src_res[k] | (WIDTH'(chunk_sum[k]) << (k * CW));
            a_d[k]   = src_a[k] >> CW;
            b_d[k]   = src_b[k] >> CW;
        end
        ovf_d = chunk_cmsb[STAGES-1] ^ chunk_cout[STAGES-1];
    end

    // Data fields load only with a valid token so outputs stay 0 until the first result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else if (advance_c) begin
            vld_q <= src_v;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (src_v[k]) begin
                    res_q[k] <= res_d[k];
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                    cy_q[k]  <= chunk_cout[k];
                end
            end
            if (src_v[STAGES-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign c_out     = cy_q[STAGES-1];
    assign overflow  = ovf_q;

    logic unused_tail;
    assign unused_tail = ^{chunk_cmsb, a_q[STAGES-1], b_q[STAGES-1]};

endmodule
